// File: rtl/fuzzy_pkg.sv
// Shared types, widths and rule-walk helpers for the zero-order Sugeno sequencer.
package fuzzy_pkg;

    localparam int NUM_W    = 20;
    localparam int DEN_W    = 12;
    localparam int DIV_ITER = 20;

    typedef logic [2:0][7:0] mu3_t;
    typedef logic [8:0][7:0] g9_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FUZZ  = 3'd1,
        S_RULES = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Corner rules used in 4-rule mode, entry 0 is visited first.
    localparam logic [3:0][3:0] RULE_IDX_4 = {4'd8, 4'd6, 4'd2, 4'd0};

    // Split a rule index k = 3*i + j into {i, j}.
    function automatic logic [3:0] rule_ij(input logic [3:0] k);
        logic [3:0] ij;
        case (k)
            4'd0:    ij = {2'd0, 2'd0};
            4'd1:    ij = {2'd0, 2'd1};
            4'd2:    ij = {2'd0, 2'd2};
            4'd3:    ij = {2'd1, 2'd0};
            4'd4:    ij = {2'd1, 2'd1};
            4'd5:    ij = {2'd1, 2'd2};
            4'd6:    ij = {2'd2, 2'd0};
            4'd7:    ij = {2'd2, 2'd1};
            4'd8:    ij = {2'd2, 2'd2};
            default: ij = {2'd0, 2'd0};
        endcase
        return ij;
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fuzzy_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; done is high during the last iteration.
module fuzzy_div_seq #(
    parameter int NUM_W = fuzzy_pkg::NUM_W,
    parameter int DEN_W = fuzzy_pkg::DEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [7:0]       quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] q;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;

    always_comb begin
        trial = {rem, q[NUM_W-1]};
        diff  = trial[DEN_W-1:0] - dsr;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            q   <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            q   <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= CNT_W'(NUM_W);
            run <= 1'b1;
        end else if (run) begin
            if (trial >= {1'b0, dsr}) begin
                rem <= diff;
                q   <= {q[NUM_W-2:0], 1'b1};
            end else begin
                rem <= trial[DEN_W-1:0];
                q   <= {q[NUM_W-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
                run <= 1'b0;
        end
    end

    // The final quotient is below 256, so only the low byte is exported.
    assign quotient = q[7:0];
    assign done     = run && (cnt == CNT_W'(1));

endmodule

// File: rtl/fuzzy_seq_ctrl.sv
// Sugeno inference sequencer: snapshot memberships, min/MAC over the rule base, divide, clamp.
//   state   | meaning
//   S_IDLE  | waiting for start_pulse, result registers hold last value
//   S_FUZZ  | latch membership snapshot, clear accumulators
//   S_RULES | one rule per cycle: num += w*g, den += w
//   S_DIV   | divider kicked on entry, wait for done
//   S_DONE  | publish clamped quotient, raise valid, drop busy
module fuzzy_seq_ctrl
    import fuzzy_pkg::*;
#(
    parameter int G_MAX = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       init_pulse,
    input  logic       reg_mode,
    input  mu3_t       mu_T,
    input  mu3_t       mu_dT,
    input  g9_t        g_vec,
    output logic [7:0] G_out,
    output logic       busy,
    output logic       valid,
    output logic       div_zero
);

    seq_state_t       state;
    logic             mode9;
    logic [3:0]       rule_cnt;
    mu3_t             mu_t_snap;
    mu3_t             mu_dt_snap;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic             div_start;
    logic             div_done;
    logic [7:0]       div_q;

    logic [3:0]       rule_k;
    logic [3:0]       ij;
    logic [7:0]       w;
    logic [7:0]       g_sel;
    logic [15:0]      prod;
    logic             last_rule;
    logic [7:0]       q_clamped;

    always_comb begin
        rule_k    = mode9 ? rule_cnt : RULE_IDX_4[rule_cnt[1:0]];
        ij        = rule_ij(rule_k);
        w         = min8(mu_t_snap[ij[3:2]], mu_dt_snap[ij[1:0]]);
        g_sel     = g_vec[rule_k];
        prod      = 16'(w) * 16'(g_sel);
        last_rule = mode9 ? (rule_cnt == 4'd8) : (rule_cnt == 4'd3);
        q_clamped = (div_q > 8'(G_MAX)) ? 8'(G_MAX) : div_q;
    end

    always_ff @(posedge clk) begin
        if (rst || init_pulse) begin
            state      <= S_IDLE;
            mode9      <= 1'b0;
            rule_cnt   <= '0;
            mu_t_snap  <= '0;
            mu_dt_snap <= '0;
            num        <= '0;
            den        <= '0;
            div_start  <= 1'b0;
            G_out      <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        state <= S_FUZZ;
                        mode9 <= reg_mode;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end
                end
                S_FUZZ: begin
                    mu_t_snap  <= mu_T;
                    mu_dt_snap <= mu_dT;
                    num        <= '0;
                    den        <= '0;
                    rule_cnt   <= '0;
                    state      <= S_RULES;
                end
                S_RULES: begin
                    num <= num + NUM_W'(prod);
                    den <= den + DEN_W'(w);
                    if (last_rule) begin
                        state     <= S_DIV;
                        div_start <= 1'b1;
                    end else begin
                        rule_cnt <= rule_cnt + 4'd1;
                    end
                end
                S_DIV: begin
                    if (div_done)
                        state <= S_DONE;
                end
                S_DONE: begin
                    // Zero total firing strength has no meaningful quotient.
                    if (den == '0) begin
                        G_out    <= '0;
                        div_zero <= 1'b1;
                    end else begin
                        G_out    <= q_clamped;
                        div_zero <= 1'b0;
                    end
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fuzzy_div_seq #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (init_pulse),
        .dividend (num),
        .divisor  (den),
        .quotient (div_q),
        .done     (div_done)
    );

endmodule
